un_bitnand_check: RTL

UN_BITNAND_CHECK -- requirements
Module: un_bitnand_check

---
 rtl/un_bitnand_check_pkg.sv | 15 +
 rtl/un_bitnand_check_misr32_step.sv | 26 ++
 rtl/un_bitnand_check.sv | 137 +++++++++++++
 3 files changed

// File: rtl/un_bitnand_check_pkg.sv
// Shared types and constants for the reduction-NAND result checker.
package un_bitnand_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned SIG_W     = 32;
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/un_bitnand_check_misr32_step.sv
// One MISR step: fold a W-bit vector to 32 bits and merge it into the shifted signature.
module misr32_step
    import un_bitnand_check_pkg::*;
#(
    parameter int unsigned W = 128
) (
    input  logic [31:0]  sig_in,
    input  logic [W-1:0] data_in,
    output logic [31:0]  sig_out_c
);

    localparam int unsigned NUM_SLICE = W / 32;

    logic [31:0] fold_c;
    logic [31:0] shift_c;

    always_comb begin
        fold_c = '0;
        for (int unsigned i = 0; i < NUM_SLICE; i++) begin
            fold_c = fold_c ^ data_in[i*32 +: 32];
        end
        shift_c   = {sig_in[30:0], 1'b0} ^ (sig_in[31] ? MISR_POLY : 32'h0);
        sig_out_c = shift_c ^ fold_c;
    end

endmodule

// File: rtl/un_bitnand_check.sv
// Compares NUM_VEC reduction-NAND results against golden vectors, counting
// mismatches, capturing the first one and compressing all data into a MISR.
module un_bitnand_check
    import un_bitnand_check_pkg::*;
#(
    parameter int unsigned W       = 128,
    parameter int unsigned NUM_VEC = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic [W-1:0] in_expect,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [15:0]  vec_count,
    output logic [15:0]  err_count,
    output logic [15:0]  first_err_idx,
    output logic [W-1:0] first_err_xor,
    output logic [31:0]  signature
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VEC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   vec_count_q, vec_count_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;
    logic [CNT_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic [W-1:0]       first_err_xor_q, first_err_xor_d;
    logic [SIG_W-1:0]   signature_q, signature_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;

    logic               accept_c;
    logic               mismatch_c;
    logic [SIG_W-1:0]   misr_next_c;

    misr32_step #(.W(W)) u_misr (
        .sig_in    (signature_q),
        .data_in   (in_data),
        .sig_out_c (misr_next_c)
    );

    // in_ready_q always mirrors state_q == ST_RUN, so no path from in_valid to in_ready.
    assign accept_c   = in_valid && in_ready_q;
    assign mismatch_c = (in_data != in_expect);

    always_comb begin
        state_d         = state_q;
        vec_count_d     = vec_count_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_xor_d = first_err_xor_q;
        signature_d     = signature_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d         = ST_RUN;
                    vec_count_d     = '0;
                    err_count_d     = '0;
                    first_err_idx_d = '0;
                    first_err_xor_d = '0;
                    signature_d     = MISR_SEED;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    vec_count_d = vec_count_q + CNT_W'(1);
                    signature_d = misr_next_c;
                    if (mismatch_c) begin
                        if (err_count_q != CNT_MAX) begin
                            err_count_d = err_count_q + CNT_W'(1);
                        end
                        // err_count saturates and never wraps, so zero means no earlier mismatch
                        if (err_count_q == '0) begin
                            first_err_idx_d = vec_count_q;
                            first_err_xor_d = in_data ^ in_expect;
                        end
                    end
                    if (vec_count_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d = (state_d == ST_RUN);
        busy_d     = (state_d == ST_RUN);
        done_d     = (state_d == ST_DONE);
        pass_d     = (state_d == ST_DONE) && (err_count_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            vec_count_q     <= '0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_xor_q <= '0;
            signature_q     <= MISR_SEED;
            in_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            pass_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            vec_count_q     <= vec_count_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_xor_q <= first_err_xor_d;
            signature_q     <= signature_d;
            in_ready_q      <= in_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            pass_q          <= pass_d;
        end
    end

    assign in_ready      = in_ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign vec_count     = vec_count_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_xor = first_err_xor_q;
    assign signature     = signature_q;

endmodule
